// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Purpose  : Shared widths and FSM state encoding for word_byte_sequencer.
// Contents : WORD_W, BYTE_W, NBYTES, state_t (ST_IDLE / ST_SEND)
// Revision : 1.0 - initial release
// ============================================================================
package seq_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int NBYTES = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage : seq_pkg
`default_nettype wire

// File: rtl/word_byte_sequencer_splitter.sv
`default_nettype none
// ============================================================================
// Module   : word_byte_sequencer_splitter
// Purpose  : Splits a 32-bit word into its four bytes, O1 = most significant.
// Ports    : A  - input word
//            O1 - A[31:24], O2 - A[23:16], O3 - A[15:8], O4 - A[7:0]
// Revision : 1.0 - initial release
// ============================================================================
module word_byte_sequencer_splitter
    import seq_pkg::*;
(
    input  logic [WORD_W-1:0] A,
    output logic [BYTE_W-1:0] O1,
    output logic [BYTE_W-1:0] O2,
    output logic [BYTE_W-1:0] O3,
    output logic [BYTE_W-1:0] O4
);

    assign O1 = A[31:24];
    assign O2 = A[23:16];
    assign O3 = A[15:8];
    assign O4 = A[7:0];

endmodule : word_byte_sequencer_splitter
`default_nettype wire

// File: rtl/word_byte_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : word_byte_sequencer
// Purpose  : Serialises 32-bit words into a byte stream, one byte per beat,
//            with valid/ready handshakes on both sides.
// Params   : MSB_FIRST - 1: A[31:24] first; 0: A[7:0] first
// Macro    : WORD_BYTE_SEQUENCER_SKID_EN - adds a one-word skid buffer so the
//            next word can be taken while the current one is being sent,
//            giving 4 cycles/word sustained (5 cycles/word without it).
// Ports    : clk, reset (sync, active-high)
//            in_valid / in_data / in_ready   - word input stream
//            out_valid / out_byte / out_ready / out_last - byte output stream
//            busy - a word is in flight (SEND, or skid occupied)
// Revision : 1.0 - initial release
// ============================================================================
module word_byte_sequencer
    import seq_pkg::*;
#(
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [BYTE_W-1:0] out_byte,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy
);

    localparam logic [1:0] c_last_idx = 2'(NBYTES - 1);

    state_t            r_state, w_state_nxt;
    logic [WORD_W-1:0] r_word,  w_word_nxt;
    logic [1:0]        r_idx,   w_idx_nxt;
    logic [1:0]        w_sel;
    logic [BYTE_W-1:0] w_o1, w_o2, w_o3, w_o4;
    logic              w_in_acc;
    logic              w_beat;
    logic              w_last_beat;

`ifdef WORD_BYTE_SEQUENCER_SKID_EN
    logic [WORD_W-1:0] r_skid,      w_skid_nxt;
    logic              r_skid_full, w_skid_full_nxt;
`endif

    word_byte_sequencer_splitter u_splitter (
        .A  (r_word),
        .O1 (w_o1),
        .O2 (w_o2),
        .O3 (w_o3),
        .O4 (w_o4)
    );

    // Handshake outputs depend on registered state only, so out_ready
    // never reaches in_ready combinationally.
`ifdef WORD_BYTE_SEQUENCER_SKID_EN
    assign in_ready = (r_state == ST_IDLE) || !r_skid_full;
    assign busy     = (r_state == ST_SEND) || r_skid_full;
`else
    assign in_ready = (r_state == ST_IDLE);
    assign busy     = (r_state == ST_SEND);
`endif

    assign out_valid   = (r_state == ST_SEND);
    assign out_last    = out_valid && (r_idx == c_last_idx);
    assign w_in_acc    = in_valid && in_ready;
    assign w_beat      = out_valid && out_ready;
    assign w_last_beat = w_beat && (r_idx == c_last_idx);

    // LSB-first order simply walks the splitter outputs backwards.
    assign w_sel = (MSB_FIRST != 0) ? r_idx : (c_last_idx - r_idx);

    always_comb begin
        case (w_sel)
            2'd0:    out_byte = w_o1;
            2'd1:    out_byte = w_o2;
            2'd2:    out_byte = w_o3;
            default: out_byte = w_o4;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_idx_nxt   = r_idx;
`ifdef WORD_BYTE_SEQUENCER_SKID_EN
        w_skid_nxt      = r_skid;
        w_skid_full_nxt = r_skid_full;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_in_acc) begin
                    w_word_nxt  = in_data;
                    w_idx_nxt   = 2'd0;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
`ifdef WORD_BYTE_SEQUENCER_SKID_EN
                // A word arriving on the last beat with an empty skid goes
                // straight into r_word (bypass below); otherwise park it.
                if (w_in_acc && !(w_last_beat && !r_skid_full)) begin
                    w_skid_nxt      = in_data;
                    w_skid_full_nxt = 1'b1;
                end
`endif
                if (w_beat) begin
                    if (r_idx != c_last_idx) begin
                        w_idx_nxt = r_idx + 2'd1;
                    end
`ifdef WORD_BYTE_SEQUENCER_SKID_EN
                    else if (r_skid_full) begin
                        w_word_nxt      = r_skid;
                        w_idx_nxt       = 2'd0;
                        w_skid_full_nxt = 1'b0;
                    end
                    else if (w_in_acc) begin
                        w_word_nxt = in_data;
                        w_idx_nxt  = 2'd0;
                    end
`endif
                    else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_word  <= w_word_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

`ifdef WORD_BYTE_SEQUENCER_SKID_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_skid      <= '0;
            r_skid_full <= 1'b0;
        end else begin
            r_skid      <= w_skid_nxt;
            r_skid_full <= w_skid_full_nxt;
        end
    end
`endif

endmodule : word_byte_sequencer
`default_nettype wire

// File: tb/tb_word_byte_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_word_byte_sequencer
// Purpose  : Self-checking bench for word_byte_sequencer; runs an MSB-first
//            and an LSB-first instance side by side on shared stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_word_byte_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        in_ready_m, out_valid_m, out_last_m, busy_m;
    logic [7:0]  out_byte_m;
    logic        in_ready_l, out_valid_l, out_last_l, busy_l;
    logic [7:0]  out_byte_l;

    int tests = 0;
    int fails = 0;

    // Scoreboards: {last, byte} per expected beat
    logic [8:0] q_m[$];
    logic [8:0] q_l[$];
    logic [8:0] e_m, e_l;

    // Per-cycle samples taken at the falling edge
    logic       s_acc, s_beat, s_valid, s_in_ready, s_busy;
    logic       s_last_m, s_last_l;
    logic [7:0] s_byte_m, s_byte_l;
    logic [1:0] s_idx;

    always #5 clk = ~clk;

    word_byte_sequencer #(.MSB_FIRST(1)) dut_msb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_m), .out_valid(out_valid_m), .out_byte(out_byte_m),
        .out_ready(out_ready), .out_last(out_last_m), .busy(busy_m)
    );

    word_byte_sequencer #(.MSB_FIRST(0)) dut_lsb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_l), .out_valid(out_valid_l), .out_byte(out_byte_l),
        .out_ready(out_ready), .out_last(out_last_l), .busy(busy_l)
    );

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            q_m.push_back({(i == 3), w[31-8*i -: 8]});
            q_l.push_back({(i == 3), w[8*i +: 8]});
        end
    endtask

    function automatic logic [8:0] pop_m();
        if (q_m.size() == 0) return 9'bx;
        return q_m.pop_front();
    endfunction

    function automatic logic [8:0] pop_l();
        if (q_l.size() == 0) return 9'bx;
        return q_l.pop_front();
    endfunction

    // Sample one cycle at the falling edge, record accepted words, then
    // advance to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        s_acc      = in_valid && in_ready_m;
        s_valid    = out_valid_m;
        s_beat     = out_valid_m && out_ready;
        s_in_ready = in_ready_m;
        s_busy     = busy_m;
        s_byte_m   = out_byte_m;
        s_last_m   = out_last_m;
        s_byte_l   = out_byte_l;
        s_last_l   = out_last_l;
        s_idx      = dut_msb.r_idx;
        if (s_acc) push_word(in_data);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            tick();
            tests += 6;
            if (s_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid[%0d]: got %b, want 0", k, s_valid); end
            if (s_byte_m !== 8'h00) begin fails++; $display("FAIL reset_out_byte_msb[%0d]: got %h, want 00", k, s_byte_m); end
            if (s_byte_l !== 8'h00) begin fails++; $display("FAIL reset_out_byte_lsb[%0d]: got %h, want 00", k, s_byte_l); end
            if (s_last_m !== 1'b0) begin fails++; $display("FAIL reset_out_last[%0d]: got %b, want 0", k, s_last_m); end
            if (s_busy !== 1'b0) begin fails++; $display("FAIL reset_busy[%0d]: got %b, want 0", k, s_busy); end
            if (s_in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready[%0d]: got %b, want 1", k, s_in_ready); end
            reset = 1'b0;
        end
    endtask

    task automatic test_single();
        int nb = 0, first = -1, lastc = -1;
        in_data = 32'h86DEF0A3; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 20 && nb < 4; c++) begin
            tick();
            if (s_acc) in_valid = 1'b0;
            if (s_beat) begin
                e_m = pop_m(); e_l = pop_l(); tests += 2;
                if ({s_last_m, s_byte_m} !== e_m) begin fails++; $display("FAIL single_msb beat %0d: got last=%b byte=%h, want %h", nb, s_last_m, s_byte_m, e_m); end
                if ({s_last_l, s_byte_l} !== e_l) begin fails++; $display("FAIL single_lsb beat %0d: got last=%b byte=%h, want %h", nb, s_last_l, s_byte_l, e_l); end
                if (first < 0) first = c;
                lastc = c;
                nb++;
            end
        end
        tests += 2;
        if (nb !== 4) begin fails++; $display("FAIL single_beats: got %0d, want 4", nb); end
        if (lastc - first !== 3) begin fails++; $display("FAIL single_consecutive: got span %0d, want 3", lastc - first); end
        tick();
        tests += 2;
        if (s_in_ready !== 1'b1) begin fails++; $display("FAIL single_idle_in_ready: got %b, want 1", s_in_ready); end
        if (s_valid !== 1'b0) begin fails++; $display("FAIL single_idle_out_valid: got %b, want 0", s_valid); end
    endtask

    task automatic test_backpressure();
        int nb = 0, stall = 0;
        in_data = 32'h12345678; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 40 && nb < 4; c++) begin
            tick();
            if (s_acc) in_valid = 1'b0;
            if (stall > 0) begin
                tests += 5;
                if (s_valid !== 1'b1) begin fails++; $display("FAIL bp_valid: got %b, want 1", s_valid); end
                if (s_byte_m !== 8'h34) begin fails++; $display("FAIL bp_hold_msb: got %h, want 34", s_byte_m); end
                if (s_byte_l !== 8'h56) begin fails++; $display("FAIL bp_hold_lsb: got %h, want 56", s_byte_l); end
                if (s_idx !== 2'd1) begin fails++; $display("FAIL bp_idx_hold: got %0d, want 1", s_idx); end
                if (s_last_m !== 1'b0) begin fails++; $display("FAIL bp_last: got %b, want 0", s_last_m); end
                stall--;
                if (stall == 0) out_ready = 1'b1;
            end
            if (s_beat) begin
                e_m = pop_m(); e_l = pop_l(); tests += 2;
                if ({s_last_m, s_byte_m} !== e_m) begin fails++; $display("FAIL bp_msb beat %0d: got last=%b byte=%h, want %h", nb, s_last_m, s_byte_m, e_m); end
                if ({s_last_l, s_byte_l} !== e_l) begin fails++; $display("FAIL bp_lsb beat %0d: got last=%b byte=%h, want %h", nb, s_last_l, s_byte_l, e_l); end
                nb++;
                if (nb == 1) begin out_ready = 1'b0; stall = 3; end
            end
        end
        tests++;
        if (nb !== 4) begin fails++; $display("FAIL bp_beats: got %0d, want 4", nb); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        int nb = 0, nacc = 0, gaps = 0, exp_gaps;
`ifdef WORD_BYTE_SEQUENCER_SKID_EN
        exp_gaps = 0;
`else
        exp_gaps = 1;
`endif
        in_data = 32'h11223344; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 40 && nb < 8; c++) begin
            tick();
            if (s_acc) begin
                nacc++;
                if (nacc == 1) in_data = 32'hAABBCCDD;
                else in_valid = 1'b0;
            end
            if (nb > 0 && !s_valid) gaps++;
            if (s_beat) begin
                e_m = pop_m(); e_l = pop_l(); tests += 2;
                if ({s_last_m, s_byte_m} !== e_m) begin fails++; $display("FAIL b2b_msb beat %0d: got last=%b byte=%h, want %h", nb, s_last_m, s_byte_m, e_m); end
                if ({s_last_l, s_byte_l} !== e_l) begin fails++; $display("FAIL b2b_lsb beat %0d: got last=%b byte=%h, want %h", nb, s_last_l, s_byte_l, e_l); end
                nb++;
            end
        end
        tests += 2;
        if (nb !== 8) begin fails++; $display("FAIL b2b_beats: got %0d, want 8", nb); end
        if (gaps !== exp_gaps) begin fails++; $display("FAIL b2b_gaps: got %0d, want %0d", gaps, exp_gaps); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_skid_full();
        logic [31:0] w[3];
        int nb = 0, nacc = 0, acc3_c = -1, beat4_c = -1, exp_acc;
        w[0] = 32'hC0C1C2C3; w[1] = 32'hD0D1D2D3; w[2] = 32'hE0E1E2E3;
`ifdef WORD_BYTE_SEQUENCER_SKID_EN
        exp_acc = 2;
`else
        exp_acc = 1;
`endif
        in_data = w[0]; in_valid = 1'b1; out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (s_acc) begin
                nacc++;
                if (nacc < 3) in_data = w[nacc];
                else in_valid = 1'b0;
            end
        end
        tests += 5;
        if (nacc !== exp_acc) begin fails++; $display("FAIL stall_accepts: got %0d, want %0d", nacc, exp_acc); end
        if (s_in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready: got %b, want 0", s_in_ready); end
        if (s_busy !== 1'b1) begin fails++; $display("FAIL stall_busy: got %b, want 1", s_busy); end
        if (s_valid !== 1'b1) begin fails++; $display("FAIL stall_valid: got %b, want 1", s_valid); end
        if (s_byte_m !== 8'hC0) begin fails++; $display("FAIL stall_byte: got %h, want C0", s_byte_m); end
        out_ready = 1'b1;
        for (int c = 0; c < 60 && nb < 12; c++) begin
            tick();
            if (s_acc) begin
                nacc++;
                if (nacc == 3) acc3_c = c;
                if (nacc < 3) in_data = w[nacc];
                else in_valid = 1'b0;
            end
            if (s_beat) begin
                e_m = pop_m(); e_l = pop_l(); tests += 2;
                if ({s_last_m, s_byte_m} !== e_m) begin fails++; $display("FAIL skid_msb beat %0d: got last=%b byte=%h, want %h", nb, s_last_m, s_byte_m, e_m); end
                if ({s_last_l, s_byte_l} !== e_l) begin fails++; $display("FAIL skid_lsb beat %0d: got last=%b byte=%h, want %h", nb, s_last_l, s_byte_l, e_l); end
                nb++;
                if (nb == 4) beat4_c = c;
            end
        end
        tests++;
        if (nb !== 12) begin fails++; $display("FAIL skid_beats: got %0d, want 12", nb); end
`ifdef WORD_BYTE_SEQUENCER_SKID_EN
        tests++;
        if (acc3_c - beat4_c !== 1) begin fails++; $display("FAIL skid_third_accept: got %0d cycles after last beat, want 1", acc3_c - beat4_c); end
`endif
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int nb = 0, nacc = 0;
        in_data = 32'h86DEF0A3; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 20 && nb < 2; c++) begin
            tick();
            if (s_acc) begin
                nacc++;
                if (nacc == 1) in_data = 32'h55667788;
                else in_valid = 1'b0;
            end
            if (s_beat) begin
                e_m = pop_m(); e_l = pop_l(); tests += 2;
                if ({s_last_m, s_byte_m} !== e_m) begin fails++; $display("FAIL rmid_msb beat %0d: got last=%b byte=%h, want %h", nb, s_last_m, s_byte_m, e_m); end
                if ({s_last_l, s_byte_l} !== e_l) begin fails++; $display("FAIL rmid_lsb beat %0d: got last=%b byte=%h, want %h", nb, s_last_l, s_byte_l, e_l); end
                nb++;
            end
        end
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        reset = 1'b0;
        q_m.delete(); q_l.delete();
        tick();
        tests += 4;
        if (s_valid !== 1'b0) begin fails++; $display("FAIL rmid_out_valid: got %b, want 0", s_valid); end
        if (s_busy !== 1'b0) begin fails++; $display("FAIL rmid_busy: got %b, want 0", s_busy); end
        if (s_in_ready !== 1'b1) begin fails++; $display("FAIL rmid_in_ready: got %b, want 1", s_in_ready); end
        if (s_last_m !== 1'b0) begin fails++; $display("FAIL rmid_out_last: got %b, want 0", s_last_m); end
        nb = 0;
        in_data = 32'h01020304; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 20 && nb < 4; c++) begin
            tick();
            if (s_acc) in_valid = 1'b0;
            if (s_beat) begin
                e_m = pop_m(); e_l = pop_l(); tests += 2;
                if ({s_last_m, s_byte_m} !== e_m) begin fails++; $display("FAIL rpost_msb beat %0d: got last=%b byte=%h, want %h", nb, s_last_m, s_byte_m, e_m); end
                if ({s_last_l, s_byte_l} !== e_l) begin fails++; $display("FAIL rpost_lsb beat %0d: got last=%b byte=%h, want %h", nb, s_last_l, s_byte_l, e_l); end
                nb++;
            end
        end
        tests++;
        if (nb !== 4) begin fails++; $display("FAIL rpost_beats: got %0d, want 4", nb); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_skid_full();
        test_reset_mid();
        tests++;
        if (q_m.size() != 0) begin fails++; $display("FAIL leftover_expected: got %0d queued, want 0", q_m.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule : tb_word_byte_sequencer
`default_nettype wire
